lsq_multiport: RTL and testbench

Parametrised in-order load/store queue for the Tomasulo core, between the issue stage, the ROB, the wakeup (CDB) buses and the memory controller. It generalises the load/store buffer in three ways. Depth, ROB-tag width and the IO boundary are parameters. It snoops NUM_WB wakeup buses plus its own load bus. It reports store readiness from any queue position, not only the head. Committed stores survive a branch flush and drain to memory.

---
 rtl/lsq_multiport.sv | 219 +++++++++++++++++++++
 tb/tb_lsq_multiport.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsq_multiport.sv
// rtl/lsq_multiport.sv - in-order load/store queue with multi-bus wakeup snooping,
// store-readiness reporting and flush-surviving committed stores.
module lsq_multiport #(
  parameter int          DEPTH       = 16,
  parameter int          ROB_W       = 4,
  parameter int          NUM_WB      = 2,
  parameter int          FULL_MARGIN = 2,
  parameter logic [31:0] IO_BASE     = 32'h0003_0000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rdy,
  input  logic                       flush,
  input  logic [ROB_W-1:0]           rob_head_id,
  input  logic                       issue_valid,
  input  logic                       issue_is_store,
  input  logic                       issue_unsigned,
  input  logic [1:0]                 issue_size,
  input  logic [31:0]                issue_vj,
  input  logic [31:0]                issue_vk,
  input  logic [31:0]                issue_imm,
  input  logic                       issue_rj,
  input  logic                       issue_rk,
  input  logic [ROB_W-1:0]           issue_qj,
  input  logic [ROB_W-1:0]           issue_qk,
  input  logic [ROB_W-1:0]           issue_rob_id,
  input  logic                       commit_valid,
  input  logic [ROB_W-1:0]           commit_rob_id,
  input  logic [NUM_WB-1:0]          wb_valid,
  input  logic [NUM_WB*ROB_W-1:0]    wb_rob,
  input  logic [NUM_WB*32-1:0]       wb_value,
  output logic                       mem_req,
  output logic                       mem_we,
  output logic [1:0]                 mem_size,
  output logic [31:0]                mem_addr,
  output logic [31:0]                mem_wdata,
  input  logic                       mem_done,
  input  logic [31:0]                mem_rdata,
  output logic                       ld_valid,
  output logic [ROB_W-1:0]           ld_rob_id,
  output logic [31:0]                ld_value,
  output logic                       st_ready,
  output logic [ROB_W-1:0]           st_rob_id,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       almost_full
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] PONE   = (PW+1)'(1);
  localparam logic [PW:0] AF_LVL = (PW+1)'(DEPTH - FULL_MARGIN);

  typedef enum logic {S_IDLE, S_REQ} state_t;
  state_t state, state_n;

  logic [PW:0] head, tail, cptr;
  logic [DEPTH-1:0] committed, st_reported, killed, is_store, uns, rj, rk;
  logic [1:0]       size_q [DEPTH];
  logic [31:0]      vj_q [DEPTH], vk_q [DEPTH], imm_q [DEPTH];
  logic [ROB_W-1:0] qj_q [DEPTH], qk_q [DEPTH], tag_q [DEPTH];

  // Returns {hit, value} for a producer tag seen on any wakeup bus or the own load bus.
  function automatic logic [32:0] snoop(input logic [ROB_W-1:0] q);
    logic [32:0] r;
    r = '0;
    for (int b = 0; b < NUM_WB; b++)
      if (wb_valid[b] && wb_rob[b*ROB_W +: ROB_W] == q) r = {1'b1, wb_value[b*32 +: 32]};
    if (ld_valid && ld_rob_id == q) r = {1'b1, ld_value};
    return r;
  endfunction

  logic [PW-1:0] hidx, tidx, cidx, sidx, st_idx, off;
  logic [DEPTH-1:0] in_q, wj_hit, wk_hit;
  logic [31:0] wj_val [DEPTH], wk_val [DEPTH];
  logic [32:0] byp_j, byp_k;
  logic [31:0] head_addr, ld_ext;
  logic head_ok, start, pop, kill, commit_hit, st_found;
  logic [PW:0] cp_c, cp_n, head_n, tail_n;

  assign hidx        = head[PW-1:0];
  assign tidx        = tail[PW-1:0];
  assign cidx        = cptr[PW-1:0];
  assign count       = tail - head;
  assign almost_full = (count >= AF_LVL);
  assign head_addr   = vj_q[hidx] + imm_q[hidx];
  assign byp_j       = snoop(issue_qj);
  assign byp_k       = snoop(issue_qk);

  always_comb begin
    off = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off       = PW'(i) - hidx;
      in_q[i]   = ({1'b0, off} < count);
      {wj_hit[i], wj_val[i]} = snoop(qj_q[i]);
      {wk_hit[i], wk_val[i]} = snoop(qk_q[i]);
    end
  end

  always_comb begin
    if (count == '0)
      head_ok = 1'b0;
    else if (is_store[hidx])
      head_ok = rj[hidx] && rk[hidx] && committed[hidx];
    else
      head_ok = rj[hidx] && (head_addr < IO_BASE || tag_q[hidx] == rob_head_id);
  end

  // A flushed uncommitted load must not be launched; committed stores keep going.
  assign start      = (state == S_IDLE) && head_ok && !(flush && !is_store[hidx]);
  assign pop        = (state == S_REQ) && mem_done;
  assign commit_hit = commit_valid && (cptr != tail) && (tag_q[cidx] == commit_rob_id);
  assign cp_c       = commit_hit ? cptr + PONE : cptr;
  assign cp_n       = (pop && cp_c == head) ? head + PONE : cp_c;
  assign kill       = flush && (state == S_REQ) && !is_store[hidx] && (cp_c == head) && !mem_done;
  assign head_n     = pop ? head + PONE : head;

  always_comb begin
    tail_n = tail;
    if (flush)            tail_n = kill ? head + PONE : cp_n;
    else if (issue_valid) tail_n = tail + PONE;
  end

  // Descending scan so the last hit is the oldest store.
  always_comb begin
    st_found = 1'b0;
    st_idx   = '0;
    sidx     = '0;
    for (int k = DEPTH-1; k >= 0; k--) begin
      sidx = hidx + PW'(k);
      if (in_q[sidx] && is_store[sidx] && !st_reported[sidx] &&
          (rj[sidx] || wj_hit[sidx]) && (rk[sidx] || wk_hit[sidx])) begin
        st_found = 1'b1;
        st_idx   = sidx;
      end
    end
  end

  always_comb begin
    case (size_q[hidx])
      2'd0:    ld_ext = uns[hidx] ? {24'b0, mem_rdata[7:0]}  : {{24{mem_rdata[7]}}, mem_rdata[7:0]};
      2'd1:    ld_ext = uns[hidx] ? {16'b0, mem_rdata[15:0]} : {{16{mem_rdata[15]}}, mem_rdata[15:0]};
      default: ld_ext = mem_rdata;
    endcase
  end

  always_comb begin
    state_n = state;
    mem_req = 1'b0;
    case (state)
      S_IDLE: if (start) state_n = S_REQ;
      S_REQ: begin
        mem_req = 1'b1;
        if (mem_done) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)      state <= S_IDLE;
    else if (rdy) state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head <= '0; tail <= '0; cptr <= '0;
      committed <= '0; st_reported <= '0; killed <= '0;
      is_store <= '0; uns <= '0; rj <= '0; rk <= '0;
      ld_valid <= 1'b0; ld_rob_id <= '0; ld_value <= '0;
      st_ready <= 1'b0; st_rob_id <= '0;
      mem_we <= 1'b0; mem_size <= '0; mem_addr <= '0; mem_wdata <= '0;
    end else if (!rdy) begin
      ld_valid <= 1'b0; ld_rob_id <= '0; ld_value <= '0;
      st_ready <= 1'b0; st_rob_id <= '0;
    end else begin
      ld_valid <= 1'b0; ld_rob_id <= '0; ld_value <= '0;
      st_ready <= 1'b0; st_rob_id <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        if (!rj[i] && wj_hit[i]) begin rj[i] <= 1'b1; vj_q[i] <= wj_val[i]; end
        if (!rk[i] && wk_hit[i]) begin rk[i] <= 1'b1; vk_q[i] <= wk_val[i]; end
      end
      if (commit_hit) committed[cidx] <= 1'b1;
      if (kill) killed[hidx] <= 1'b1;
      if (st_found && !flush) begin
        st_ready            <= 1'b1;
        st_rob_id           <= tag_q[st_idx];
        st_reported[st_idx] <= 1'b1;
      end
      if (pop && !is_store[hidx] && !killed[hidx] && !flush) begin
        ld_valid  <= 1'b1;
        ld_rob_id <= tag_q[hidx];
        ld_value  <= ld_ext;
      end
      if (start) begin
        mem_we    <= is_store[hidx];
        mem_size  <= size_q[hidx];
        mem_addr  <= head_addr;
        mem_wdata <= vk_q[hidx];
      end
      if (issue_valid && !flush) begin
        is_store[tidx]    <= issue_is_store;
        uns[tidx]         <= issue_unsigned;
        size_q[tidx]      <= issue_size;
        imm_q[tidx]       <= issue_imm;
        tag_q[tidx]       <= issue_rob_id;
        qj_q[tidx]        <= issue_qj;
        qk_q[tidx]        <= issue_qk;
        rj[tidx]          <= issue_rj || byp_j[32];
        rk[tidx]          <= issue_rk || byp_k[32];
        vj_q[tidx]        <= issue_rj ? issue_vj : byp_j[31:0];
        vk_q[tidx]        <= issue_rk ? issue_vk : byp_k[31:0];
        committed[tidx]   <= 1'b0;
        st_reported[tidx] <= 1'b0;
        killed[tidx]      <= 1'b0;
      end
      head <= head_n;
      tail <= tail_n;
      cptr <= cp_n;
    end
  end
endmodule

// File: tb/tb_lsq_multiport.sv
// tb/tb_lsq_multiport.sv - directed bench for lsq_multiport (DEPTH=4, two wakeup buses).
module tb_lsq_multiport;
  localparam int DEPTH = 4;
  localparam int ROB_W = 4;
  localparam int NUM_WB = 2;

  logic clk = 1'b0;
  logic rst, rdy, flush;
  logic [ROB_W-1:0] rob_head_id;
  logic issue_valid, issue_is_store, issue_unsigned;
  logic [1:0] issue_size;
  logic [31:0] issue_vj, issue_vk, issue_imm;
  logic issue_rj, issue_rk;
  logic [ROB_W-1:0] issue_qj, issue_qk, issue_rob_id;
  logic commit_valid;
  logic [ROB_W-1:0] commit_rob_id;
  logic [NUM_WB-1:0] wb_valid;
  logic [NUM_WB*ROB_W-1:0] wb_rob;
  logic [NUM_WB*32-1:0] wb_value;
  logic mem_req, mem_we;
  logic [1:0] mem_size;
  logic [31:0] mem_addr, mem_wdata;
  logic mem_done;
  logic [31:0] mem_rdata;
  logic ld_valid;
  logic [ROB_W-1:0] ld_rob_id;
  logic [31:0] ld_value;
  logic st_ready;
  logic [ROB_W-1:0] st_rob_id;
  logic [$clog2(DEPTH):0] count;
  logic almost_full;

  int checks = 0;
  int errors = 0;

  lsq_multiport #(.DEPTH(DEPTH), .ROB_W(ROB_W), .NUM_WB(NUM_WB), .FULL_MARGIN(2),
                  .IO_BASE(32'h0003_0000)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush), .rob_head_id(rob_head_id),
    .issue_valid(issue_valid), .issue_is_store(issue_is_store), .issue_unsigned(issue_unsigned),
    .issue_size(issue_size), .issue_vj(issue_vj), .issue_vk(issue_vk), .issue_imm(issue_imm),
    .issue_rj(issue_rj), .issue_rk(issue_rk), .issue_qj(issue_qj), .issue_qk(issue_qk),
    .issue_rob_id(issue_rob_id), .commit_valid(commit_valid), .commit_rob_id(commit_rob_id),
    .wb_valid(wb_valid), .wb_rob(wb_rob), .wb_value(wb_value),
    .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_done(mem_done), .mem_rdata(mem_rdata),
    .ld_valid(ld_valid), .ld_rob_id(ld_rob_id), .ld_value(ld_value),
    .st_ready(st_ready), .st_rob_id(st_rob_id), .count(count), .almost_full(almost_full)
  );

  always #5 clk = ~clk;

  // Issuing into a full queue is illegal.
  always @(negedge clk) begin
    if (!rst && rdy && issue_valid && !flush)
      assert (count < 3'(DEPTH)) else begin
        errors++;
        $error("FAIL issue_when_full observed=%0d expected=<%0d", count, DEPTH);
      end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic iss(input logic st, input logic un, input logic [1:0] sz,
                     input logic [31:0] vj, input logic [31:0] vk, input logic [31:0] imm,
                     input logic rj, input logic rk, input logic [3:0] qj, input logic [3:0] qk,
                     input logic [3:0] id);
    issue_valid = 1'b1; issue_is_store = st; issue_unsigned = un; issue_size = sz;
    issue_vj = vj; issue_vk = vk; issue_imm = imm; issue_rj = rj; issue_rk = rk;
    issue_qj = qj; issue_qk = qk; issue_rob_id = id;
  endtask

  task automatic iss_tick(input logic st, input logic un, input logic [1:0] sz,
                          input logic [31:0] vj, input logic [31:0] vk, input logic [31:0] imm,
                          input logic rj, input logic rk, input logic [3:0] qj,
                          input logic [3:0] qk, input logic [3:0] id);
    iss(st, un, sz, vj, vk, imm, rj, rk, qj, qk, id);
    tick();
    issue_valid = 1'b0;
  endtask

  task automatic wait_req(input string tag);
    int n;
    n = 0;
    while (mem_req !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    chk(tag, 32'(mem_req), 32'd1);
  endtask

  task automatic done(input logic [31:0] d);
    mem_done = 1'b1;
    mem_rdata = d;
    tick();
    mem_done = 1'b0;
  endtask

  task automatic run_load(input string tag, input logic [1:0] sz, input logic un,
                          input logic [31:0] addr, input logic [31:0] rdata,
                          input logic [3:0] id, input logic [31:0] want);
    iss_tick(1'b0, un, sz, addr, 32'h0, 32'h0, 1'b1, 1'b0, 4'd0, 4'd0, id);
    wait_req({tag, "_req"});
    chk({tag, "_addr"}, mem_addr, addr);
    done(rdata);
    chk({tag, "_valid"}, 32'(ld_valid), 32'd1);
    chk({tag, "_value"}, ld_value, want);
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; flush = 1'b0; rob_head_id = '0;
    issue_valid = 1'b0; issue_is_store = 1'b0; issue_unsigned = 1'b0; issue_size = '0;
    issue_vj = '0; issue_vk = '0; issue_imm = '0; issue_rj = 1'b0; issue_rk = 1'b0;
    issue_qj = '0; issue_qk = '0; issue_rob_id = '0;
    commit_valid = 1'b0; commit_rob_id = '0;
    wb_valid = '0; wb_rob = '0; wb_value = '0;
    mem_done = 1'b0; mem_rdata = '0;
    repeat (3) tick();
    rst = 1'b0;

    chk("rst_count", 32'(count), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_ld_valid", 32'(ld_valid), 32'd0);
    chk("rst_st_ready", 32'(st_ready), 32'd0);
    chk("rst_almost_full", 32'(almost_full), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);

    rdy = 1'b0;
    iss_tick(1'b0, 1'b0, 2'd2, 32'h100, 32'h0, 32'h4, 1'b1, 1'b0, 4'd0, 4'd0, 4'd1);
    rdy = 1'b1;
    chk("rdy_hold_count", 32'(count), 32'd0);
    chk("rdy_hold_req", 32'(mem_req), 32'd0);

    iss_tick(1'b0, 1'b0, 2'd2, 32'h100, 32'h0, 32'h4, 1'b1, 1'b0, 4'd0, 4'd0, 4'd1);
    chk("lw_count", 32'(count), 32'd1);
    chk("lw_req_early", 32'(mem_req), 32'd0);
    tick();
    chk("lw_req", 32'(mem_req), 32'd1);
    chk("lw_addr", mem_addr, 32'h104);
    chk("lw_size", 32'(mem_size), 32'd2);
    chk("lw_we", 32'(mem_we), 32'd0);
    tick();
    chk("lw_req_held", 32'(mem_req), 32'd1);
    done(32'hDEADBEEF);
    chk("lw_ld_valid", 32'(ld_valid), 32'd1);
    chk("lw_ld_id", 32'(ld_rob_id), 32'd1);
    chk("lw_ld_value", ld_value, 32'hDEADBEEF);
    chk("lw_req_drop", 32'(mem_req), 32'd0);
    chk("lw_count_pop", 32'(count), 32'd0);
    tick();
    chk("lw_ld_pulse", 32'(ld_valid), 32'd0);

    run_load("lb", 2'd0, 1'b0, 32'h140, 32'hABCDEF80, 4'd2, 32'hFFFFFF80);
    run_load("lbu", 2'd0, 1'b1, 32'h141, 32'hABCDEF80, 4'd3, 32'h00000080);
    run_load("lh", 2'd1, 1'b0, 32'h142, 32'h12348001, 4'd4, 32'hFFFF8001);
    run_load("lhu", 2'd1, 1'b1, 32'h144, 32'h12348001, 4'd4, 32'h00008001);
    run_load("below_io", 2'd0, 1'b1, 32'h0002FFFF, 32'h7F, 4'd13, 32'h7F);

    iss_tick(1'b0, 1'b0, 2'd2, 32'h100, 32'h0, 32'h0, 1'b1, 1'b0, 4'd0, 4'd0, 4'd10);
    iss_tick(1'b0, 1'b0, 2'd2, 32'h0, 32'h0, 32'h8, 1'b0, 1'b0, 4'd10, 4'd0, 4'd11);
    wait_req("chain_req_a");
    chk("chain_addr_a", mem_addr, 32'h100);
    done(32'h600);
    chk("chain_val_a", ld_value, 32'h600);
    wait_req("chain_req_b");
    chk("chain_addr_b", mem_addr, 32'h608);
    done(32'h1);
    chk("chain_id_b", 32'(ld_rob_id), 32'd11);

    iss_tick(1'b1, 1'b0, 2'd2, 32'h200, 32'h0, 32'h0, 1'b1, 1'b0, 4'd0, 4'd3, 4'd6);
    chk("sw_st_ready_wait0", 32'(st_ready), 32'd0);
    tick();
    chk("sw_st_ready_wait1", 32'(st_ready), 32'd0);
    wb_valid = 2'b10; wb_rob = {4'd3, 4'd0}; wb_value = {32'h55, 32'h0};
    tick();
    wb_valid = '0;
    chk("sw_st_ready", 32'(st_ready), 32'd1);
    chk("sw_st_id", 32'(st_rob_id), 32'd6);
    tick();
    chk("sw_st_ready_once", 32'(st_ready), 32'd0);
    chk("sw_no_req_uncommitted", 32'(mem_req), 32'd0);
    commit_valid = 1'b1; commit_rob_id = 4'd6;
    tick();
    commit_valid = 1'b0;
    chk("sw_req_commit_cycle", 32'(mem_req), 32'd0);
    tick();
    chk("sw_req", 32'(mem_req), 32'd1);
    chk("sw_we", 32'(mem_we), 32'd1);
    chk("sw_addr", mem_addr, 32'h200);
    chk("sw_wdata", mem_wdata, 32'h55);
    done(32'h0);
    chk("sw_req_drop", 32'(mem_req), 32'd0);
    chk("sw_no_ld", 32'(ld_valid), 32'd0);
    chk("sw_count", 32'(count), 32'd0);

    iss_tick(1'b1, 1'b0, 2'd2, 32'h300, 32'h1234, 32'h0, 1'b1, 1'b1, 4'd0, 4'd0, 4'd7);
    chk("fl_count1", 32'(count), 32'd1);
    iss(1'b0, 1'b0, 2'd2, 32'h400, 32'h0, 32'h0, 1'b1, 1'b0, 4'd0, 4'd0, 4'd8);
    commit_valid = 1'b1; commit_rob_id = 4'd7;
    tick();
    issue_valid = 1'b0; commit_valid = 1'b0;
    chk("fl_count2", 32'(count), 32'd2);
    chk("fl_almost_full", 32'(almost_full), 32'd1);
    chk("fl_st_ready", 32'(st_ready), 32'd1);
    chk("fl_st_id", 32'(st_rob_id), 32'd7);
    tick();
    chk("fl_req", 32'(mem_req), 32'd1);
    chk("fl_we", 32'(mem_we), 32'd1);
    chk("fl_addr", mem_addr, 32'h300);
    chk("fl_wdata", mem_wdata, 32'h1234);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fl_count_after", 32'(count), 32'd1);
    chk("fl_req_kept", 32'(mem_req), 32'd1);
    tick();
    chk("fl_count_hold", 32'(count), 32'd1);
    done(32'h0);
    chk("fl_count_done", 32'(count), 32'd0);
    chk("fl_no_ld", 32'(ld_valid), 32'd0);
    tick();
    chk("fl_load_dropped", 32'(mem_req), 32'd0);

    iss_tick(1'b0, 1'b0, 2'd2, 32'h500, 32'h0, 32'h0, 1'b1, 1'b0, 4'd0, 4'd0, 4'd9);
    tick();
    chk("kill_req", 32'(mem_req), 32'd1);
    flush = 1'b1;
    iss(1'b0, 1'b0, 2'd2, 32'h600, 32'h0, 32'h0, 1'b1, 1'b0, 4'd0, 4'd0, 4'd12);
    tick();
    flush = 1'b0; issue_valid = 1'b0;
    chk("kill_count", 32'(count), 32'd1);
    chk("kill_req_kept", 32'(mem_req), 32'd1);
    done(32'h77);
    chk("kill_no_ld", 32'(ld_valid), 32'd0);
    chk("kill_count_done", 32'(count), 32'd0);
    tick();
    chk("kill_no_ld_late", 32'(ld_valid), 32'd0);
    chk("kill_idle", 32'(mem_req), 32'd0);

    rob_head_id = 4'd4;
    iss_tick(1'b0, 1'b0, 2'd0, 32'h00030000, 32'h0, 32'h0, 1'b1, 1'b0, 4'd0, 4'd0, 4'd5);
    tick();
    tick();
    chk("io_wait", 32'(mem_req), 32'd0);
    rob_head_id = 4'd5;
    tick();
    chk("io_req", 32'(mem_req), 32'd1);
    chk("io_addr", mem_addr, 32'h00030000);
    chk("io_size", 32'(mem_size), 32'd0);
    done(32'hFF);
    chk("io_value", ld_value, 32'hFFFFFFFF);
    rob_head_id = 4'd0;

    for (int r = 0; r < 4; r++) begin
      for (int j = 0; j < 3; j++) begin
        iss_tick(1'b0, 1'b0, 2'd2, 32'h1000 + 32'(r * 256 + j * 4), 32'h0, 32'h0,
                 1'b1, 1'b0, 4'd0, 4'd0, 4'(j + 1));
        chk("af_count", 32'(count), 32'(j + 1));
        chk("af_flag", 32'(almost_full), (j >= 1) ? 32'd1 : 32'd0);
      end
      for (int j = 0; j < 3; j++) begin
        wait_req("wrap_req");
        chk("wrap_addr", mem_addr, 32'h1000 + 32'(r * 256 + j * 4));
        done(32'(r * 16 + j));
        chk("wrap_id", 32'(ld_rob_id), 32'(j + 1));
        chk("wrap_value", ld_value, 32'(r * 16 + j));
      end
      chk("wrap_count0", 32'(count), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
